// File: rtl/batch_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | batch_scheduler_if : run enable and address/strobe bundle, Rev 1.0     |
// +------------------------------------------------------------------------+
interface batch_scheduler_if #(
   parameter int DEPTH_DS = 15
);
   localparam int CW  = $clog2(DEPTH_DS);
   localparam int SAW = CW + 2;
   localparam int RAW = CW + 1;

   logic           en;
   logic [CW-1:0]  batCnt;
   logic [CW-1:0]  batCntRev;
   logic [1:0]     cycle;
   logic           cycleEnd;
   logic           sampleWrite;
   logic [SAW-1:0] addrIn;
   logic [SAW-1:0] addrLH;
   logic [SAW-1:0] addrBR;
   logic [SAW-1:0] addrFR;
   logic           resWrite;
   logic [RAW-1:0] addrResIn;
   logic [RAW-1:0] addrResOutB;
   logic [RAW-1:0] addrResOutF;
   logic           regProp;
   logic           validCompute;
   logic           valid;

   modport master (
      input  en,
      output batCnt, batCntRev, cycle, cycleEnd, sampleWrite,
             addrIn, addrLH, addrBR, addrFR,
             resWrite, addrResIn, addrResOutB, addrResOutF,
             regProp, validCompute, valid
   );

   modport slave (
      output en,
      input  batCnt, batCntRev, cycle, cycleEnd, sampleWrite,
             addrIn, addrLH, addrBR, addrFR,
             resWrite, addrResIn, addrResOutB, addrResOutF,
             regProp, validCompute, valid
   );
endinterface
`default_nettype wire

// File: rtl/batch_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | batch_scheduler : batch counters, bank rotation and memory addressing  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module batch_scheduler #(
   parameter int DEPTH_DS  = 15,
   parameter int LUT_DELAY = 2
) (
   input  wire logic         clkDS,
   input  wire logic         rst,
   batch_scheduler_if.master bus
);
   localparam int RES_DELAY  = LUT_DELAY + 3;
   localparam int PROP_DELAY = LUT_DELAY + 1;
   localparam int COMP_TIME  = 3 * DEPTH_DS + LUT_DELAY;
   localparam int VALID_TIME = 5 * DEPTH_DS;
   localparam int CW         = $clog2(DEPTH_DS);
   localparam int SAW        = CW + 2;
   localparam int RAW        = CW + 1;
   localparam int CNT_W      = $clog2(VALID_TIME + 1);

   localparam logic [CW-1:0]    LAST      = CW'(DEPTH_DS - 1);
   localparam logic [CNT_W-1:0] COMP_CNT  = CNT_W'(COMP_TIME);
   localparam logic [CNT_W-1:0] VALID_CNT = CNT_W'(VALID_TIME);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      COMPUTE = 2'd2,
      RUN     = 2'd3
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [CNT_W-1:0]               cnt;
   logic [CW-1:0]                  bat_cnt;
   logic [CW-1:0]                  bat_cnt_rev;
   logic [1:0]                     cycle;
   logic [1:0]                     cycle_lh;
   logic [1:0]                     cycle_calc;
   logic                           cycle_end;
   logic                           sample_write;
   logic                           valid_compute;
   logic                           valid_all;
   logic [RES_DELAY-1:0][CW-1:0]   res_bat_pipe;
   logic [RES_DELAY-1:0][CW-1:0]   res_rev_pipe;
   logic [RES_DELAY-1:0]           res_bank_pipe;
   logic [RES_DELAY-1:0]           vc_pipe;
   logic [PROP_DELAY-1:0]          prop_pipe;
   logic [SAW-1:0]                 addr_in;
   logic [SAW-1:0]                 addr_lh;
   logic [SAW-1:0]                 addr_br;
   logic [SAW-1:0]                 addr_fr;
   logic [RAW-1:0]                 addr_res_in;
   logic [RAW-1:0]                 addr_res_out_b;
   logic [RAW-1:0]                 addr_res_out_f;

   // The lookahead and calc banks trail the write bank by a fixed offset; the
   // idle bank (cycle+2) is never addressed, so it is not materialised.
   assign cycle_lh   = cycle + 2'd3;
   assign cycle_calc = cycle + 2'd1;

   always_ff @(posedge clkDS or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sample_write  = 1'b0;
      cycle_end     = 1'b0;
      valid_compute = (cnt >= COMP_CNT);
      valid_all     = (cnt >= VALID_CNT);
      case (state)
         IDLE:    state_nxt = FILL;
         FILL:    if (cnt == COMP_CNT)  state_nxt = COMPUTE;
         COMPUTE: if (cnt == VALID_CNT) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE) begin
         sample_write = 1'b1;
         cycle_end    = (bat_cnt == LAST);
      end
      if (!bus.en) begin
         state_nxt = IDLE;
      end
   end

   // Dropping en is a synchronous clear back to the exact reset image.
   always_ff @(posedge clkDS or negedge rst) begin
      if (!rst) begin
         cnt            <= '0;
         bat_cnt        <= '0;
         bat_cnt_rev    <= LAST;
         cycle          <= 2'd0;
         res_bat_pipe   <= '0;
         res_rev_pipe   <= {RES_DELAY{LAST}};
         res_bank_pipe  <= '0;
         vc_pipe        <= '0;
         prop_pipe      <= '1;
         addr_in        <= '0;
         addr_lh        <= '0;
         addr_br        <= '0;
         addr_fr        <= '0;
         addr_res_in    <= '0;
         addr_res_out_b <= '0;
         addr_res_out_f <= '0;
      end else if (!bus.en) begin
         cnt            <= '0;
         bat_cnt        <= '0;
         bat_cnt_rev    <= LAST;
         cycle          <= 2'd0;
         res_bat_pipe   <= '0;
         res_rev_pipe   <= {RES_DELAY{LAST}};
         res_bank_pipe  <= '0;
         vc_pipe        <= '0;
         prop_pipe      <= '1;
         addr_in        <= '0;
         addr_lh        <= '0;
         addr_br        <= '0;
         addr_fr        <= '0;
         addr_res_in    <= '0;
         addr_res_out_b <= '0;
         addr_res_out_f <= '0;
      end else begin
         if (cnt != VALID_CNT) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (bat_cnt == LAST) begin
            bat_cnt     <= '0;
            bat_cnt_rev <= LAST;
            cycle       <= cycle + 2'd1;
         end else begin
            bat_cnt     <= bat_cnt + CW'(1);
            bat_cnt_rev <= bat_cnt_rev - CW'(1);
         end
         res_bat_pipe   <= {res_bat_pipe[RES_DELAY-2:0], bat_cnt};
         res_rev_pipe   <= {res_rev_pipe[RES_DELAY-2:0], bat_cnt_rev};
         res_bank_pipe  <= {res_bank_pipe[RES_DELAY-2:0], cycle[0]};
         vc_pipe        <= {vc_pipe[RES_DELAY-2:0], valid_compute};
         prop_pipe      <= {prop_pipe[PROP_DELAY-2:0], ~cycle_end};
         addr_in        <= {bat_cnt, cycle};
         addr_lh        <= {bat_cnt_rev, cycle_lh};
         addr_br        <= {bat_cnt_rev, cycle_calc};
         addr_fr        <= {bat_cnt, cycle_calc};
         // Results are read from the bank opposite the one being written.
         addr_res_in    <= {res_bat_pipe[RES_DELAY-1], res_bank_pipe[RES_DELAY-1]};
         addr_res_out_b <= {res_rev_pipe[RES_DELAY-1], ~res_bank_pipe[RES_DELAY-1]};
         addr_res_out_f <= {res_bat_pipe[RES_DELAY-1], ~res_bank_pipe[RES_DELAY-1]};
      end
   end

   assign bus.batCnt       = bat_cnt;
   assign bus.batCntRev    = bat_cnt_rev;
   assign bus.cycle        = cycle;
   assign bus.cycleEnd     = cycle_end;
   assign bus.sampleWrite  = sample_write;
   assign bus.addrIn       = addr_in;
   assign bus.addrLH       = addr_lh;
   assign bus.addrBR       = addr_br;
   assign bus.addrFR       = addr_fr;
   assign bus.resWrite     = vc_pipe[RES_DELAY-1];
   assign bus.addrResIn    = addr_res_in;
   assign bus.addrResOutB  = addr_res_out_b;
   assign bus.addrResOutF  = addr_res_out_f;
   assign bus.regProp      = prop_pipe[PROP_DELAY-1];
   assign bus.validCompute = valid_compute;
   assign bus.valid        = valid_all;
endmodule
`default_nettype wire

// File: tb/tb_batch_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_batch_scheduler : scoreboard bench for batch_scheduler, Rev 1.0     |
// +------------------------------------------------------------------------+
module tb_batch_scheduler;
   localparam int DEPTH_DS = 15;

   typedef struct {
      int         k;
      logic [3:0] bat;
      logic [3:0] rev;
      logic [1:0] cyc;
      logic       ce;
      logic       sw;
      logic [5:0] a_in;
      logic [5:0] a_lh;
      logic [5:0] a_br;
      logic [5:0] a_fr;
      logic       rw;
      logic [4:0] r_in;
      logic [4:0] r_b;
      logic [4:0] r_f;
      logic       rp;
      logic       vc;
      logic       v;
   } exp_t;

   logic clkDS = 1'b0;
   logic rst;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   k = 0;

   always #5 clkDS = ~clkDS;

   batch_scheduler_if #(.DEPTH_DS(DEPTH_DS)) bus ();

   batch_scheduler #(
      .DEPTH_DS  (DEPTH_DS),
      .LUT_DELAY (2)
   ) dut (
      .clkDS (clkDS),
      .rst   (rst),
      .bus   (bus)
   );

   // Closed-form reference: k = number of enabled edges since reset/enable.
   function automatic int bc(int j);
      return j % 15;
   endfunction

   function automatic int cy(int j);
      return (j / 15) % 4;
   endfunction

   function automatic bit ce(int j);
      if (j <= 0) return 1'b0;
      return bc(j) == 14;
   endfunction

   function automatic exp_t model(int kk);
      exp_t e;
      int   j;
      int   rj;
      e.k   = kk;
      e.bat = 4'(bc(kk));
      e.rev = 4'(14 - bc(kk));
      e.cyc = 2'(cy(kk));
      e.ce  = ce(kk);
      e.sw  = (kk > 0);
      e.rw  = (kk >= 52);
      e.vc  = (kk >= 47);
      e.v   = (kk >= 75);
      e.rp  = !ce(kk - 3);
      if (kk == 0) begin
         e.a_in = '0; e.a_lh = '0; e.a_br = '0; e.a_fr = '0;
         e.r_in = '0; e.r_b  = '0; e.r_f  = '0;
      end else begin
         j  = kk - 1;
         rj = (j >= 5) ? j - 5 : 0;
         e.a_in = {4'(bc(j)),      2'(cy(j))};
         e.a_lh = {4'(14 - bc(j)), 2'((cy(j) + 3) % 4)};
         e.a_br = {4'(14 - bc(j)), 2'((cy(j) + 1) % 4)};
         e.a_fr = {4'(bc(j)),      2'((cy(j) + 1) % 4)};
         e.r_in = {4'(bc(rj)),      1'(cy(rj) % 2)};
         e.r_b  = {4'(14 - bc(rj)), 1'(1 - cy(rj) % 2)};
         e.r_f  = {4'(bc(rj)),      1'(1 - cy(rj) % 2)};
      end
      return e;
   endfunction

   task automatic chk(input string name, input int kk, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s k=%0d got=%0d exp=%0d", name, kk, got, want);
      end
   endtask

   always @(negedge clkDS) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("batCnt",       e.k, 32'(bus.batCnt),       32'(e.bat));
         chk("batCntRev",    e.k, 32'(bus.batCntRev),    32'(e.rev));
         chk("cycle",        e.k, 32'(bus.cycle),        32'(e.cyc));
         chk("cycleEnd",     e.k, 32'(bus.cycleEnd),     32'(e.ce));
         chk("sampleWrite",  e.k, 32'(bus.sampleWrite),  32'(e.sw));
         chk("addrIn",       e.k, 32'(bus.addrIn),       32'(e.a_in));
         chk("addrLH",       e.k, 32'(bus.addrLH),       32'(e.a_lh));
         chk("addrBR",       e.k, 32'(bus.addrBR),       32'(e.a_br));
         chk("addrFR",       e.k, 32'(bus.addrFR),       32'(e.a_fr));
         chk("resWrite",     e.k, 32'(bus.resWrite),     32'(e.rw));
         chk("addrResIn",    e.k, 32'(bus.addrResIn),    32'(e.r_in));
         chk("addrResOutB",  e.k, 32'(bus.addrResOutB),  32'(e.r_b));
         chk("addrResOutF",  e.k, 32'(bus.addrResOutF),  32'(e.r_f));
         chk("regProp",      e.k, 32'(bus.regProp),      32'(e.rp));
         chk("validCompute", e.k, 32'(bus.validCompute), 32'(e.vc));
         chk("valid",        e.k, 32'(bus.valid),        32'(e.v));
      end
   end

   task automatic step(input logic e);
      bus.en = e;
      @(posedge clkDS);
      #1;
      if (!rst || !e) k = 0;
      else            k = k + 1;
      sb.push_back(model(k));
   endtask

   initial begin
      rst    = 1'b0;
      bus.en = 1'b0;
      repeat (3) step(1'b0);
      #2 rst = 1'b1;
      repeat (10) step(1'b0);
      // Long enabled run: crosses validCompute, resWrite, valid and several banks.
      repeat (90) step(1'b1);
      repeat (3) step(1'b0);
      repeat (80) step(1'b1);
      // Asynchronous reset asserted mid-cycle, checked before the next edge.
      @(posedge clkDS);
      #2 rst = 1'b0;
      #1 k = 0;
      sb.push_back(model(0));
      #4 rst = 1'b1;
      repeat (20) step(1'b1);
      @(negedge clkDS);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
